// File: rtl/sipo_rx_if.sv
// Serial-in / parallel-out receiver bus: serial input side plus parallel word handshake.
interface sipo_rx_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_vld;
    logic             sync;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             dout_rdy;
    logic             busy;
    logic             ovf;
    logic             parity_err;

    // Handshake: a word transfers on a rising edge where dout_vld=1 and dout_rdy=1;
    // dout holds steady while dout_vld=1 and not yet accepted; dout_rdy alone does nothing.
    modport master (
        output sin, sin_vld, sync, dout_rdy,
        input  dout, dout_vld, busy, ovf, parity_err
    );

    modport slave (
        input  sin, sin_vld, sync, dout_rdy,
        output dout, dout_vld, busy, ovf, parity_err
    );
endinterface

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver, MSB first, one-deep output holding register with sticky overflow.
// Optional even-parity bit after each word when SIPO_RX_PARITY_EN is defined.
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    sipo_rx_if.slave bus,
    output logic    state_dbg
);
`ifdef SIPO_RX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW  = $clog2(FRAME);
    // Only FRAME-1 bits need storing: the final frame bit is taken straight from sin.
    localparam int SRW = FRAME - 1;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next, cnt_base;
    logic [SRW-1:0]   sr;
    logic [WIDTH-1:0] word;
    logic             done;
    logic [WIDTH-1:0] dout_r;
    logic             dout_vld_r;
    logic             ovf_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // sync restarts the frame; a bit sampled on the same edge becomes bit 0 of the new word.
    always_comb begin
        cnt_base = bus.sync ? '0 : cnt;
        cnt_next = cnt_base;
        done     = 1'b0;
        if (bus.sin_vld) begin
            if (cnt_base == CW'(FRAME - 1)) begin
                cnt_next = '0;
                done     = 1'b1;
            end else begin
                cnt_next = cnt_base + 1'b1;
            end
        end
        state_next = (cnt_next == '0) ? IDLE : SHIFT;
    end

    always_comb begin
        bus.busy  = (state == SHIFT);
        state_dbg = state;
`ifdef SIPO_RX_PARITY_EN
        word = sr;
`else
        word = {sr, bus.sin};
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr         <= '0;
            dout_r     <= '0;
            dout_vld_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            if (bus.sin_vld)
                sr <= SRW'({sr, bus.sin});
            if (done) begin
                if (!dout_vld_r || bus.dout_rdy) begin
                    dout_r     <= word;
                    dout_vld_r <= 1'b1;
                end else begin
                    ovf_r <= 1'b1;
                end
            end else if (dout_vld_r && bus.dout_rdy) begin
                dout_vld_r <= 1'b0;
            end
        end
    end

`ifdef SIPO_RX_PARITY_EN
    logic perr_r;

    always_ff @(posedge clk) begin
        if (!rst_n)
            perr_r <= 1'b0;
        else if (done && (!dout_vld_r || bus.dout_rdy))
            perr_r <= (^sr) ^ bus.sin;
    end

    assign bus.parity_err = perr_r;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.dout     = dout_r;
    assign bus.dout_vld = dout_vld_r;
    assign bus.ovf      = ovf_r;
endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx; build with +define+SIPO_RX_PARITY_EN to cover the parity frame.
module tb_sipo_rx;
  localparam int W = 4;
`ifdef SIPO_RX_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk;
  logic rst_n;
  logic state_dbg;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  sipo_rx_if #(.WIDTH(W)) bus ();

  sipo_rx #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // drivers
  task automatic send_bit(input logic b);
    bus.sin     = b;
    bus.sin_vld = 1'b1;
    tick();
    bus.sin_vld = 1'b0;
    bus.sin     = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap, input bit rdy_last, input bit bad_par);
    logic [FRAME-1:0] f;
`ifdef SIPO_RX_PARITY_EN
    f = {w, (^w) ^ bad_par};
`else
    f = w;
    if (bad_par) f = w;
`endif
    for (int i = FRAME - 1; i >= 0; i--) begin
      if (i == 0 && rdy_last) bus.dout_rdy = 1'b1;
      send_bit(f[i]);
      if (i != 0) repeat (gap) tick();
    end
    if (rdy_last) bus.dout_rdy = 1'b0;
  endtask

  task automatic test_reset();
    send_bit(1'b1);
    bus.sync = 1'b1;
    do_reset();
    bus.sync = 1'b0;
    chk_cnt++;
    if ({bus.dout, bus.dout_vld, bus.busy, bus.ovf, bus.parity_err, state_dbg} !== '0) begin
      $display("FAIL reset_state: got dout=%b vld=%b busy=%b ovf=%b perr=%b st=%b exp all zero",
               bus.dout, bus.dout_vld, bus.busy, bus.ovf, bus.parity_err, state_dbg);
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [W-1:0] w;
    do_reset();
    w = 4'b1011;
    exp_q.push_back(w);
    for (int i = W - 1; i >= 1; i--) begin
      send_bit(w[i]);
      chk_cnt++;
      if (bus.busy !== 1'b1 || bus.dout_vld !== 1'b0) begin
        $display("FAIL basic_busy bit%0d: got busy=%b vld=%b exp busy=1 vld=0", W - i, bus.busy, bus.dout_vld);
      end else pass_cnt++;
    end
    send_bit(w[0]);
`ifdef SIPO_RX_PARITY_EN
    chk_cnt++;
    if (bus.dout_vld !== 1'b0 || bus.busy !== 1'b1) begin
      $display("FAIL basic_wait_parity: got vld=%b busy=%b exp vld=0 busy=1", bus.dout_vld, bus.busy);
    end else pass_cnt++;
    send_bit(^w);
`endif
    exp_w = exp_q.pop_front();
    chk_cnt++;
    if (bus.dout_vld !== 1'b1 || bus.dout !== exp_w || bus.busy !== 1'b0) begin
      $display("FAIL basic_word: got vld=%b dout=%b busy=%b exp vld=1 dout=%b busy=0",
               bus.dout_vld, bus.dout, bus.busy, exp_w);
    end else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus.dout_vld !== 1'b1 || bus.dout !== exp_w) begin
      $display("FAIL basic_hold: got vld=%b dout=%b exp vld=1 dout=%b", bus.dout_vld, bus.dout, exp_w);
    end else pass_cnt++;
    bus.dout_rdy = 1'b1;
    tick();
    bus.dout_rdy = 1'b0;
    chk_cnt++;
    if (bus.dout_vld !== 1'b0 || bus.parity_err !== 1'b0) begin
      $display("FAIL basic_accept: got vld=%b perr=%b exp vld=0 perr=0", bus.dout_vld, bus.parity_err);
    end else pass_cnt++;
  endtask

  task automatic test_gaps();
    do_reset();
    exp_q.push_back(4'b1011);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (3) begin
      tick();
      chk_cnt++;
      if (bus.dout_vld !== 1'b0 || bus.busy !== 1'b1) begin
        $display("FAIL gaps_idle: got vld=%b busy=%b exp vld=0 busy=1", bus.dout_vld, bus.busy);
      end else pass_cnt++;
    end
    send_bit(1'b1);
`ifdef SIPO_RX_PARITY_EN
    send_bit(1'b1);
    send_bit(1'b1);
`else
    send_bit(1'b1);
`endif
    exp_w = exp_q.pop_front();
    chk_cnt++;
    if (bus.dout_vld !== 1'b1 || bus.dout !== exp_w) begin
      $display("FAIL gaps_word: got vld=%b dout=%b exp vld=1 dout=%b", bus.dout_vld, bus.dout, exp_w);
    end else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    exp_q.push_back(4'b1011);
    send_word(4'b1011, 0, 1'b0, 1'b0);
    send_word(4'b0110, 0, 1'b0, 1'b0);
    exp_w = exp_q.pop_front();
    chk_cnt++;
    if (bus.dout !== exp_w || bus.dout_vld !== 1'b1 || bus.ovf !== 1'b1) begin
      $display("FAIL ovf_drop: got dout=%b vld=%b ovf=%b exp dout=%b vld=1 ovf=1",
               bus.dout, bus.dout_vld, bus.ovf, exp_w);
    end else pass_cnt++;
    bus.dout_rdy = 1'b1;
    tick();
    bus.dout_rdy = 1'b0;
    chk_cnt++;
    if (bus.dout_vld !== 1'b0 || bus.ovf !== 1'b1) begin
      $display("FAIL ovf_sticky: got vld=%b ovf=%b exp vld=0 ovf=1", bus.dout_vld, bus.ovf);
    end else pass_cnt++;
    bus.dout_rdy = 1'b1;
    tick();
    bus.dout_rdy = 1'b0;
    chk_cnt++;
    if (bus.dout_vld !== 1'b0 || bus.ovf !== 1'b1) begin
      $display("FAIL ovf_rdy_idle: got vld=%b ovf=%b exp vld=0 ovf=1", bus.dout_vld, bus.ovf);
    end else pass_cnt++;
    do_reset();
    chk_cnt++;
    if (bus.ovf !== 1'b0) begin
      $display("FAIL ovf_reset: got ovf=%b exp 0", bus.ovf);
    end else pass_cnt++;
  endtask

  task automatic test_sync();
    do_reset();
    send_bit(1'b1);
    send_bit(1'b1);
    bus.sync = 1'b1;
    send_bit(1'b0);
    bus.sync = 1'b0;
    chk_cnt++;
    if (bus.busy !== 1'b1 || bus.dout_vld !== 1'b0) begin
      $display("FAIL sync_restart: got busy=%b vld=%b exp busy=1 vld=0", bus.busy, bus.dout_vld);
    end else pass_cnt++;
    exp_q.push_back(4'b0110);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
`ifdef SIPO_RX_PARITY_EN
    send_bit(1'b0);
`endif
    exp_w = exp_q.pop_front();
    chk_cnt++;
    if (bus.dout !== exp_w || bus.dout_vld !== 1'b1 || bus.ovf !== 1'b0) begin
      $display("FAIL sync_word: got dout=%b vld=%b ovf=%b exp dout=%b vld=1 ovf=0",
               bus.dout, bus.dout_vld, bus.ovf, exp_w);
    end else pass_cnt++;
    send_bit(1'b1);
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    chk_cnt++;
    if (bus.busy !== 1'b0 || bus.dout_vld !== 1'b1 || bus.dout !== exp_w || bus.ovf !== 1'b0) begin
      $display("FAIL sync_only: got busy=%b vld=%b dout=%b ovf=%b exp busy=0 vld=1 dout=%b ovf=0",
               bus.busy, bus.dout_vld, bus.dout, bus.ovf, exp_w);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.push_back(4'b1100);
    send_word(4'b1100, 0, 1'b0, 1'b0);
    exp_w = exp_q.pop_front();
    chk_cnt++;
    if (bus.dout !== exp_w || bus.dout_vld !== 1'b1) begin
      $display("FAIL b2b_first: got dout=%b vld=%b exp dout=%b vld=1", bus.dout, bus.dout_vld, exp_w);
    end else pass_cnt++;
    exp_q.push_back(4'b0011);
    send_word(4'b0011, 1, 1'b1, 1'b0);
    exp_w = exp_q.pop_front();
    chk_cnt++;
    if (bus.dout !== exp_w || bus.dout_vld !== 1'b1 || bus.ovf !== 1'b0) begin
      $display("FAIL b2b_second: got dout=%b vld=%b ovf=%b exp dout=%b vld=1 ovf=0",
               bus.dout, bus.dout_vld, bus.ovf, exp_w);
    end else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    do_reset();
    bus.dout_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      w = W'($urandom_range(0, (1 << W) - 1));
      exp_q.push_back(w);
      send_word(w, $urandom_range(0, 2), 1'b0, 1'b0);
      exp_w = exp_q.pop_front();
      chk_cnt++;
      if (bus.dout !== exp_w || bus.dout_vld !== 1'b1 || bus.parity_err !== 1'b0) begin
        $display("FAIL random_word%0d: got dout=%b vld=%b perr=%b exp dout=%b vld=1 perr=0",
                 k, bus.dout, bus.dout_vld, bus.parity_err, exp_w);
      end else pass_cnt++;
    end
    tick();
    bus.dout_rdy = 1'b0;
    chk_cnt++;
    if (bus.dout_vld !== 1'b0 || bus.ovf !== 1'b0) begin
      $display("FAIL random_drain: got vld=%b ovf=%b exp vld=0 ovf=0", bus.dout_vld, bus.ovf);
    end else pass_cnt++;
  endtask

  task automatic test_parity();
    do_reset();
    send_word(4'b1011, 0, 1'b1, 1'b0);
    chk_cnt++;
    if (bus.dout !== 4'b1011 || bus.parity_err !== 1'b0) begin
      $display("FAIL parity_good: got dout=%b perr=%b exp dout=1011 perr=0", bus.dout, bus.parity_err);
    end else pass_cnt++;
`ifdef SIPO_RX_PARITY_EN
    send_word(4'b1011, 0, 1'b1, 1'b1);
    chk_cnt++;
    if (bus.dout !== 4'b1011 || bus.dout_vld !== 1'b1 || bus.parity_err !== 1'b1) begin
      $display("FAIL parity_bad: got dout=%b vld=%b perr=%b exp dout=1011 vld=1 perr=1",
               bus.dout, bus.dout_vld, bus.parity_err);
    end else pass_cnt++;
`endif
  endtask

  task automatic test_reset_midword();
    do_reset();
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    bus.sin = 1'b1;
    bus.sin_vld = 1'b1;
    bus.sync = 1'b1;
    bus.dout_rdy = 1'b1;
    tick();
    rst_n = 1'b1;
    bus.sin_vld = 1'b0;
    bus.sync = 1'b0;
    bus.dout_rdy = 1'b0;
    chk_cnt++;
    if (bus.busy !== 1'b0 || state_dbg !== 1'b0 || bus.dout_vld !== 1'b0) begin
      $display("FAIL midreset_clear: got busy=%b st=%b vld=%b exp 0 0 0", bus.busy, state_dbg, bus.dout_vld);
    end else pass_cnt++;
    exp_q.push_back(4'b1001);
    send_word(4'b1001, 0, 1'b0, 1'b0);
    exp_w = exp_q.pop_front();
    chk_cnt++;
    if (bus.dout !== exp_w || bus.dout_vld !== 1'b1 || bus.parity_err !== 1'b0) begin
      $display("FAIL midreset_word: got dout=%b vld=%b perr=%b exp dout=%b vld=1 perr=0",
               bus.dout, bus.dout_vld, bus.parity_err, exp_w);
    end else pass_cnt++;
  endtask

  initial begin
    rst_n        = 1'b1;
    bus.sin      = 1'b0;
    bus.sin_vld  = 1'b0;
    bus.sync     = 1'b0;
    bus.dout_rdy = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_sync();
    test_back_to_back();
    test_random();
    test_parity();
    test_reset_midword();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter: WIDTH, default 4, number of data bits per word (WIDTH >= 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 sin  input  1  serial data bit, MSB of each word first.
REQ-005 sin_vld  input  1  sin is sampled at a rising edge only when sin_vld=1.
REQ-006 sync  input  1  frame restart: discard any partial word.
REQ-007 dout  output  WIDTH  last completed parallel word.
REQ-008 dout_vld  output  1  dout holds an unconsumed word.
REQ-009 dout_rdy  input  1  consumer accepts dout at an edge where dout_vld=1.
REQ-010 busy  output  1  partial word in progress (bit counter nonzero).
REQ-011 ovf  output  1  sticky overflow: a completed word was dropped.
REQ-012 parity_err  output  1  parity result for the word in dout (see Configuration).

Function
REQ-013 Shift register sr SHALL update sr <= {sr[WIDTH-2:0], sin} on each edge with sin_vld=1; SHALL hold when sin_vld=0.
REQ-014 Bit counter SHALL count sampled bits 0..FRAME-1, FRAME = WIDTH (WIDTH+1 with parity); wraps to 0 on the edge sampling the last frame bit.
REQ-015 States: IDLE (counter=0), SHIFT (counter 1..FRAME-1); IDLE->SHIFT on first sampled bit; SHIFT->IDLE on last sampled bit or sync.
REQ-016 On the edge sampling the last data bit the word SHALL be complete; dout and dout_vld=1 SHALL be visible in the cycle after the final frame bit's sampling edge (latency 1 cycle).
REQ-017 First bit sampled SHALL land in dout[WIDTH-1], last data bit in dout[0].
REQ-018 dout_vld SHALL clear on an edge where dout_vld=1 and dout_rdy=1, unless a new word completes on that same edge, in which case dout loads the new word and dout_vld stays 1.
REQ-019 Word completing while dout_vld=1 and dout_rdy=0: new word SHALL be dropped, dout unchanged, ovf set to 1.
REQ-020 ovf SHALL remain 1 until reset.
REQ-021 dout SHALL remain stable while dout_vld=1 and not accepted.
REQ-022 sync=1 SHALL clear the counter; if sin_vld=1 on the same edge, that bit SHALL be the first bit of the new word (counter becomes 1).
REQ-023 sync SHALL not affect dout, dout_vld, ovf, or parity_err.
REQ-024 dout_rdy with dout_vld=0 SHALL have no effect.
REQ-025 busy SHALL be 1 exactly when state is SHIFT.

Reset
REQ-026 On a rising edge with rst_n=0: counter=0, state IDLE, sr=0, dout=0, dout_vld=0, ovf=0, parity_err=0, busy=0.
REQ-027 Reset mid-word SHALL discard the partial word; the first sampled bit after rst_n=1 starts a new word.
REQ-028 rst_n SHALL take priority over sync, sin_vld, and dout_rdy.

Configuration
REQ-029 Macro SIPO_RX_PARITY_EN defined: FRAME=WIDTH+1; the bit after the LSB is an even-parity bit; parity_err=1 when XOR of the WIDTH data bits and the parity bit is 1; parity_err SHALL load with dout; word delivered regardless.
REQ-030 Macro SIPO_RX_PARITY_EN undefined: FRAME=WIDTH, no parity bit, parity_err port present and tied 0.

Verification
REQ-031 Reset, then sin 1,0,1,1 with sin_vld=1 on 4 consecutive edges, dout_rdy=0 -> dout=4'b1011, dout_vld=1 the cycle after the 4th edge; busy=1 during bits 2-4.
REQ-032 Same bits with sin_vld=0 for 3 cycles between bits 2 and 3 -> dout=4'b1011; dout_vld asserts only after 4th sampled bit.
REQ-033 Words 1011 then 0110 back-to-back, dout_rdy=0 -> dout stays 4'b1011, ovf=1; then dout_rdy=1 one edge -> dout_vld=0, ovf stays 1.
REQ-034 Bits 1,1 then sync=1 with sin_vld=1 and sin=0, then 1,1,0 -> dout=4'b0110, no ovf.
REQ-035 dout_rdy=1 on the edge completing a second word while the first is pending -> dout=second word, dout_vld stays 1, ovf=0.
REQ-036 SIPO_RX_PARITY_EN defined: 1,0,1,1 + parity 1 -> parity_err=0; 1,0,1,1 + parity 0 -> parity_err=1; rst_n=0 after 2 bits -> next 5-bit frame decodes correctly.
